// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register_bus port bundle shared by the write and read ports
interface register_bus;
   logic [2:0] addr;
   logic [7:0] data;
   logic       enable;

   modport write (input addr, input data, input enable);
   modport read  (input addr, input enable, output data);
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 8x8 register file, falling-edge write, two combinational read ports
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module register_file (
   input logic        clk,
   input logic        reset,
   register_bus.write wr_bus,
   register_bus.read  rd0_bus,
   register_bus.read  rd1_bus
);

   logic [7:0] regs [8];
   logic [7:0] rd0_data;
   logic [7:0] rd1_data;

   // Writes commit on the falling edge so a value set up after a rising edge lands mid-cycle.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= 8'h00;
         end
      end else if (wr_bus.enable) begin
         regs[wr_bus.addr] <= wr_bus.data;
      end
   end

   always_comb begin
      rd0_data = rd0_bus.enable ? regs[rd0_bus.addr] : 8'h00;
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed while reset is held so a reset read is always zero.
      if (rd0_bus.enable && reset && wr_bus.enable && (wr_bus.addr == rd0_bus.addr)) begin
         rd0_data = wr_bus.data;
      end
`endif
   end

   always_comb begin
      rd1_data = rd1_bus.enable ? regs[rd1_bus.addr] : 8'h00;
`ifdef REGFILE_BYPASS_EN
      if (rd1_bus.enable && reset && wr_bus.enable && (wr_bus.addr == rd1_bus.addr)) begin
         rd1_data = wr_bus.data;
      end
`endif
   end

   assign rd0_bus.data = rd0_data;
   assign rd1_bus.data = rd1_data;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized checks of register_file against an array model
`timescale 1ns/1ps
module tb_register_file;

   logic clk;
   logic reset;
   register_bus wr_bus ();
   register_bus rd0_bus ();
   register_bus rd1_bus ();

   register_file dut (
      .clk     (clk),
      .reset   (reset),
      .wr_bus  (wr_bus),
      .rd0_bus (rd0_bus),
      .rd1_bus (rd1_bus)
   );

   int checks = 0;
   int errors = 0;
   logic cmp_en = 1'b0;
   logic [7:0] model [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference contents: what every register must hold after each falling edge.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) model[i] <= 8'h00;
      end else if (wr_bus.enable) begin
         model[wr_bus.addr] <= wr_bus.data;
      end
   end

   function automatic logic [7:0] expect_read(input logic en, input logic [2:0] addr);
      if (!en || !reset) return 8'h00;
`ifdef REGFILE_BYPASS_EN
      if (wr_bus.enable && wr_bus.addr == addr) return wr_bus.data;
`endif
      return model[addr];
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(clk) begin
      #2;
      if (cmp_en) begin
         chk("rd0_model", rd0_bus.data, expect_read(rd0_bus.enable, rd0_bus.addr));
         chk("rd1_model", rd1_bus.data, expect_read(rd1_bus.enable, rd1_bus.addr));
      end
   end

   task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      wr_bus.addr = a; wr_bus.data = d; wr_bus.enable = 1'b1;
      @(negedge clk); #1;
      wr_bus.enable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      wr_bus.addr = 3'd0; wr_bus.data = 8'h00; wr_bus.enable = 1'b0;
      rd0_bus.addr = 3'd0; rd0_bus.enable = 1'b0;
      rd1_bus.addr = 3'd0; rd1_bus.enable = 1'b0;
      #17 reset = 1'b1;
      cmp_en = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         rd0_bus.addr = 3'(i); rd0_bus.enable = 1'b1;
         rd1_bus.addr = 3'(i); rd1_bus.enable = 1'b1;
         #1;
         chk("reset_rd0", rd0_bus.data, 8'h00);
         chk("reset_rd1", rd1_bus.data, 8'h00);
      end

      for (int i = 0; i < 8; i++) write_reg(3'(i), 8'(42 + i));
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         rd0_bus.addr = 3'(i); rd1_bus.addr = 3'(i);
         #1;
         chk("fill_rd0", rd0_bus.data, 8'(42 + i));
         chk("fill_rd1", rd1_bus.data, 8'(42 + i));
      end

      @(posedge clk); #1;
      rd0_bus.addr = 3'd3; rd0_bus.enable = 1'b0;
      rd1_bus.addr = 3'd3; rd1_bus.enable = 1'b1;
      #1;
      chk("disabled_rd0", rd0_bus.data, 8'h00);
      chk("enabled_rd1", rd1_bus.data, 8'd45);

      @(posedge clk); #1;
      wr_bus.addr = 3'd5; wr_bus.data = 8'hFF; wr_bus.enable = 1'b0;
      rd0_bus.addr = 3'd5; rd0_bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("hold_r5", rd0_bus.data, 8'd47);

      @(posedge clk);
      rd0_bus.addr = 3'd7; rd0_bus.enable = 1'b1;
      wr_bus.addr = 3'd7; wr_bus.data = 8'd99; wr_bus.enable = 1'b1;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("rdw_before", rd0_bus.data, 8'd99);
`else
      chk("rdw_before", rd0_bus.data, 8'd49);
`endif
      @(negedge clk); #1;
      wr_bus.enable = 1'b0;
      chk("rdw_after", rd0_bus.data, 8'd99);

      @(posedge clk); #1;
      rd0_bus.addr = 3'd2; rd0_bus.enable = 1'b1;
      #1;
      chk("pre_rst_r2", rd0_bus.data, 8'd44);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_rd", rd0_bus.data, 8'h00);
      wr_bus.addr = 3'd2; wr_bus.data = 8'd77; wr_bus.enable = 1'b1;
      @(negedge clk); #1;
      chk("rst_wr_blocked", rd0_bus.data, 8'h00);
      wr_bus.enable = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("post_rst_r2", rd0_bus.data, 8'h00);

      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         wr_bus.enable = 1'($urandom_range(0, 1));
         wr_bus.addr = 3'($urandom_range(0, 7));
         wr_bus.data = 8'($urandom);
         rd0_bus.enable = ($urandom_range(0, 3) != 0);
         rd0_bus.addr = 3'($urandom_range(0, 7));
         rd1_bus.enable = ($urandom_range(0, 3) != 0);
         rd1_bus.addr = ($urandom_range(0, 3) == 0) ? rd0_bus.addr : 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) begin
            #2 reset = 1'b0;
            #1 reset = 1'b1;
         end
      end

      @(posedge clk); #1;
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
